dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane.sv | 49 ++++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Used by dmem_lane and dmem_responder.
package dmem_pkg;

  localparam logic [2:0] Func3Byte  = 3'b000;
  localparam logic [2:0] Func3Half  = 3'b001;
  localparam logic [2:0] Func3Word  = 3'b010;
  localparam logic [2:0] Func3ByteU = 3'b100;
  localparam logic [2:0] Func3HalfU = 3'b101;

  localparam int unsigned WaitCyclesDefault = 2;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for loads and stores.
// Produces the write mask, replicated store data and the extended load result.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword accesses use the lane pair picked by addr[1]; addr[0] is dropped.
  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (func3_i)
      Func3Byte, Func3ByteU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (func3_i == Func3Byte) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      Func3Half, Func3HalfU: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (func3_i == Func3Half) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        misalign_o = addr_lo_i[0];
      end
      Func3Word: begin
        be_o       = 4'b1111;
        rdata_o    = rword_i;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: IDLE -> BUSY -> DONE.
// Define DMEM_MISALIGN_TRAP_EN to add the err output and suppress misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = WaitCyclesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned AddrW = IdxW + 2;

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       readdata_q;
  logic              accept;
  logic              fire;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [IdxW-1:0]   idx;
  logic [31:0]       rword;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              lane_misalign;
  logic              trap;
  logic [3:0]        wr_be;

  // Bits above the array size wrap around.
  logic unused_addr;
  assign unused_addr = ^addr[31:AddrW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign stall = ((state_q == StIdle) && req) || (state_q == StBusy);
  assign ready = (state_q == StDone);

  assign idx   = addr_q[AddrW-1:2];
  assign rword = mem_q[idx];

  dmem_lane u_lane (
    .func3_i    (func3_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = lane_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = lane_misalign;
  assign trap = 1'b0;
`endif

  assign wr_be = (fire && we_q && !trap) ? lane_be : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      func3_q    <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      readdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        func3_q <= func3;
        addr_q  <= addr[AddrW-1:0];
        wdata_q <= wdata;
      end
      if (fire && !we_q) begin
        readdata_q <= trap ? 32'h0 : lane_rdata;
      end
    end
  end

  // Storage is intentionally not reset; fire is already held low by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  assign readdata = readdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire && trap;
    end
  end
  assign err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-array reference model.
// Honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_responder;

  localparam int unsigned Depth    = 256;
  localparam int unsigned WaitCyc  = 2;
  localparam int unsigned MemBytes = Depth * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, readdata;
  logic        ready, stall;
  logic        req2, we2;
  logic [2:0]  func3_2;
  logic [31:0] addr2, wdata2, readdata2;
  logic        ready2, stall2;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err, err2;
  bit          exp_err;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(WaitCyc)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .func3    (func3),
    .addr     (addr),
    .wdata    (wdata),
    .readdata (readdata),
    .ready    (ready),
    .stall    (stall)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .err      (err)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req2),
    .we       (we2),
    .func3    (func3_2),
    .addr     (addr2),
    .wdata    (wdata2),
    .readdata (readdata2),
    .ready    (ready2),
    .stall    (stall2)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .err      (err2)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  bit [7:0]    mm [MemBytes];
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory is a flat byte array, accesses are (size, base) byte runs.
  function automatic void model_op(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                   input bit [31:0] d);
    int unsigned sz;
    bit [31:0]   base;
    bit [31:0]   v;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_err = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    if (exp_err) begin
      if (!w) exp_rd = 32'h0;
      return;
    end
`endif
    if (sz == 0) begin
      if (!w) exp_rd = 32'h0;
      return;
    end
    base = (a & ~(sz - 1)) % MemBytes;
    if (w) begin
      for (int i = 0; i < int'(sz); i++) mm[base + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mm[base + i];
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
  endfunction

  // Starts and ends on a negedge with the DUT idle.
  task automatic op(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    int k;
    bit got;
    bit stall_bad;
    req = 1'b1; we = w; func3 = f3; addr = a; wdata = d;
    #1 check("stall_idle_req", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); func3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    model_op(w, f3, a, d);
    k = 0; got = 1'b0; stall_bad = 1'b0;
    while (!got && k < int'(WaitCyc) + 8) begin
      @(negedge clk);
      k++;
      if (ready === 1'b1) got = 1'b1;
      else if (stall !== 1'b1) stall_bad = 1'b1;
    end
    check("latency", got ? 32'(k) : 32'd0, 32'(WaitCyc + 2));
    check("stall_busy", 32'(stall_bad), 32'd0);
    check("stall_done", 32'(stall), 32'd0);
    check("readdata", readdata, exp_rd);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("err", 32'(err), 32'(exp_err));
`endif
    @(negedge clk);
    check("ready_pulse", 32'(ready), 32'd0);
  endtask

  logic [2:0]  f3tab [10];
  logic [31:0] prior;
  logic [15:0] prior_h;

  initial begin
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7};
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; func3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    req2 = 1'b0; we2 = 1'b0; func3_2 = 3'd0; addr2 = 32'h0; wdata2 = 32'h0;
    exp_rd = 32'h0;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(Depth); i++) op(1'b1, 3'd2, 32'(i * 4), $urandom);

    // Word store/load round trip.
    op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    op(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_deadbeef", readdata, 32'hDEAD_BEEF);

    // Byte store, signed and unsigned reloads.
    op(1'b1, 3'd0, 32'h13, 32'h0000_0080);
    op(1'b0, 3'd0, 32'h13, 32'h0);
    check("lb_sext", readdata, 32'hFFFF_FF80);
    op(1'b0, 3'd4, 32'h13, 32'h0);
    check("lbu_zext", readdata, 32'h0000_0080);
    op(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_merged", readdata, 32'h80AD_BEEF);

    // Upper halfword store leaves the lower pair untouched.
    prior_h = {mm[32'h21], mm[32'h20]};
    op(1'b1, 3'd1, 32'h22, 32'h0000_8001);
    op(1'b0, 3'd1, 32'h22, 32'h0);
    check("lh_sext", readdata, 32'hFFFF_8001);
    op(1'b0, 3'd5, 32'h22, 32'h0);
    check("lhu_zext", readdata, 32'h0000_8001);
    op(1'b0, 3'd5, 32'h20, 32'h0);
    check("lower_half_kept", readdata, {16'h0, prior_h});

    // Reset while a store waits must abort it.
    prior = {mm[32'h33], mm[32'h32], mm[32'h31], mm[32'h30]};
    req = 1'b1; we = 1'b1; func3 = 3'd2; addr = 32'h30; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_readdata", readdata, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (ready === 1'b1) seen = 1'b1;
      end
      check("aborted_no_ready", 32'(seen), 32'd0);
    end
    op(1'b0, 3'd2, 32'h30, 32'h0);
    check("aborted_store", readdata, prior);

    // Misaligned word load.
    op(1'b1, 3'd2, 32'h0, 32'hCAFE_F00D);
    op(1'b0, 3'd2, 32'h2, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_lw", readdata, 32'h0);
`else
    check("misalign_lw", readdata, 32'hCAFE_F00D);
`endif

    for (int n = 0; n < 200; n++) begin
      op(1'($urandom), f3tab[$urandom_range(0, 9)], $urandom, $urandom);
    end

    // Zero-wait instance: aliasing and back-to-back throughput.
    req2 = 1'b1; we2 = 1'b1; func3_2 = 3'd2; addr2 = 32'h400; wdata2 = 32'h5A5A_1234;
    @(posedge clk);
    #1 req2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w0_store_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; func3_2 = 3'd2; addr2 = 32'h000;
    #1 check("w0_stall_req", 32'(stall2), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("w0_ready", 32'(ready2), 32'((k % 3) == 2));
      check("w0_stall", 32'(stall2), 32'((k % 3) != 2));
      if ((k % 3) == 2) check("w0_alias", readdata2, 32'h5A5A_1234);
    end
    req2 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
